// File: rtl/uart_tx_engine.sv
// UART transmit engine: first-word-fall-through FIFO feeding a baud-paced frame serializer.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_engine #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          n_we_i,
    output logic                          p_full_o,
    output logic                          p_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    input  logic                          p_BaudSig_i,
    input  logic                          p_ParityEnable_i,
    input  logic                          ParityMethod_i,
    input  logic                          p_BigEnd_i,
    input  logic                          p_TwoStop_i,
`ifdef UART_TX_BREAK_EN
    input  logic                          p_Break_i,
`endif
    output logic                          Tx_o,
    output logic                          p_Busy_o,
    output logic                          p_Done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP1   = 3'd4,
        STOP2   = 3'd5
`ifdef UART_TX_BREAK_EN
        ,
        BRK     = 3'd6,
        BRK_GAP = 3'd7
`endif
    } state_t;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    function automatic logic [DATA_W-1:0] reverse_bits(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [LW-1:0]     level_nxt_s;
    logic              full_r;
    logic              empty_r;
    logic              wr_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;

    state_t            state_r;
    logic [DATA_W-1:0] sh_r;
    logic [CW-1:0]     bit_cnt_r;
    logic              par_en_r;
    logic              par_r;
    logic              two_stop_r;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;

    assign head_s    = mem_r[rd_ptr_r];
    assign wr_s      = ~n_we_i & ~full_r;
    assign p_full_o  = full_r;
    assign p_empty_o = empty_r;
    assign level_o   = level_r;
    assign Tx_o      = tx_r;
    assign p_Busy_o  = busy_r;
    assign p_Done_o  = done_r;

    // Pop on the baud pulse that starts a frame; break in IDLE takes priority over data.
    always_comb begin
        pop_s = 1'b0;
        if (p_BaudSig_i && !empty_r) begin
            case (state_r)
`ifdef UART_TX_BREAK_EN
                IDLE:    pop_s = ~p_Break_i;
                BRK_GAP: pop_s = 1'b1;
`else
                IDLE:    pop_s = 1'b1;
`endif
                STOP1:   pop_s = ~two_stop_r;
                STOP2:   pop_s = 1'b1;
                default: pop_s = 1'b0;
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Occupancy after this clock's write and pop.
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_s && !rst) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // FIFO pointers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LW'(FIFO_DEPTH));
            empty_r <= (level_nxt_s == LW'(0));
        end
    end

    // Frame sequencer; every output is registered and changes only on baud pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sh_r       <= '0;
            bit_cnt_r  <= '0;
            par_en_r   <= 1'b0;
            par_r      <= 1'b0;
            two_stop_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (p_BaudSig_i) begin
                case (state_r)
                    IDLE: begin
`ifdef UART_TX_BREAK_EN
                        if (p_Break_i) begin
                            state_r <= BRK;
                            tx_r    <= 1'b0;
                            busy_r  <= 1'b1;
                        end else
`endif
                        if (!empty_r) begin
                            state_r <= START;
                            tx_r    <= 1'b0;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                    START: begin
                        state_r   <= DATA;
                        tx_r      <= sh_r[0];
                        sh_r      <= {1'b0, sh_r[DATA_W-1:1]};
                        bit_cnt_r <= '0;
                    end
                    DATA: begin
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= par_en_r ? PARITY : STOP1;
                            tx_r    <= par_en_r ? par_r : 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CW'(1);
                            tx_r      <= sh_r[0];
                            sh_r      <= {1'b0, sh_r[DATA_W-1:1]};
                        end
                    end
                    PARITY: begin
                        state_r <= STOP1;
                        tx_r    <= 1'b1;
                    end
                    STOP1, STOP2: begin
                        if (state_r == STOP1 && two_stop_r) begin
                            state_r <= STOP2;
                            tx_r    <= 1'b1;
                        end else begin
                            done_r <= 1'b1;
                            if (!empty_r) begin
                                state_r <= START;
                                tx_r    <= 1'b0;
                            end else begin
                                state_r <= IDLE;
                                tx_r    <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
`ifdef UART_TX_BREAK_EN
                    BRK: begin
                        if (!p_Break_i) begin
                            state_r <= BRK_GAP;
                            tx_r    <= 1'b1;
                        end else begin
                            state_r <= BRK;
                            tx_r    <= 1'b0;
                        end
                    end
                    BRK_GAP: begin
                        if (!empty_r) begin
                            state_r <= START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state_r <= IDLE;
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
            // Word and frame options are frozen at pop time so later config changes wait a frame.
            if (pop_s) begin
                sh_r       <= p_BigEnd_i ? reverse_bits(head_s) : head_s;
                par_en_r   <= p_ParityEnable_i;
                par_r      <= calc_parity(head_s, ParityMethod_i);
                two_stop_r <= p_TwoStop_i;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: expected frames queued at write time, line decoded per baud pulse.
module tb_uart_tx_engine;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       n_we;
    logic       p_full, p_empty;
    logic [5:0] level;
    logic       baud;
    logic       par_en, par_odd, big_end, two_stop;
    logic       tx, busy, done;
`ifdef UART_TX_BREAK_EN
    logic       brk = 1'b0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          spurious = 0;
    int unsigned sample_n = 0;
    logic        last_bit = 1'b1;
    bit          baud_en = 1'b0;
    bit          baud_force = 1'b0;
    bit          mon_flush = 1'b0;
    bit          mon_hold = 1'b0;
    bit          in_frame = 1'b0;
    int          got_n = 0;
    logic [15:0] got_v;
    frame_t      exp_q[$];

    always #5 clk = ~clk;

    uart_tx_engine dut (
        .clk              (clk),
        .rst              (rst),
        .data_i           (data_i),
        .n_we_i           (n_we),
        .p_full_o         (p_full),
        .p_empty_o        (p_empty),
        .level_o          (level),
        .p_BaudSig_i      (baud),
        .p_ParityEnable_i (par_en),
        .ParityMethod_i   (par_odd),
        .p_BigEnd_i       (big_end),
        .p_TwoStop_i      (two_stop),
`ifdef UART_TX_BREAK_EN
        .p_Break_i        (brk),
`endif
        .Tx_o             (tx),
        .p_Busy_o         (busy),
        .p_Done_o         (done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic frame_t mk_frame(input logic [7:0] d, input bit pe, input bit odd,
                                        input bit big, input bit two);
        frame_t f;
        int n;
        f.bits = '0;
        f.bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = big ? d[7-i] : d[i];
            n++;
        end
        if (pe) begin
            f.bits[n] = (^d) ^ odd;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (two) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len = n;
        return f;
    endfunction

    // Baud generator plus line monitor: one sample per bit period, taken just after the baud edge.
    initial begin
        int cnt = 0;
        baud = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
            if (mon_flush) begin
                in_frame  = 1'b0;
                mon_flush = 1'b0;
            end else if (baud && !rst) begin
                sample_n++;
                last_bit = tx;
                if (!mon_hold) begin
                    if (!in_frame) begin
                        if (tx === 1'b0) begin
                            if (exp_q.size() == 0) begin
                                spurious++;
                            end else begin
                                in_frame = 1'b1;
                                got_v    = '0;
                                got_n    = 1;
                            end
                        end
                    end else begin
                        got_v[got_n] = tx;
                        got_n++;
                        if (got_n == exp_q[0].len) begin
                            frame_t e;
                            e = exp_q.pop_front();
                            check_val("frame", {16'h0, got_v}, {16'h0, e.bits});
                            in_frame = 1'b0;
                        end
                    end
                end
            end
            baud = (baud_en && cnt == 3) || baud_force;
            cnt  = (cnt + 1) % 4;
        end
    end

    task automatic push_word(input logic [7:0] d, input bit keep);
        @(negedge clk);
        data_i = d;
        n_we   = 1'b0;
        if (keep) exp_q.push_back(mk_frame(d, par_en, par_odd, big_end, two_stop));
    endtask

    task automatic end_write();
        @(negedge clk);
        n_we = 1'b1;
    endtask

    task automatic wait_busy(input int max);
        int t = 0;
        while (busy !== 1'b1 && t < max) begin
            @(negedge clk);
            t++;
        end
        #2;
        check_val("busy_rise", busy, 1);
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < max) begin
            @(negedge clk);
            t++;
        end
        #2;
        check_val("drain_q", exp_q.size(), 0);
        check_val("drain_busy", busy, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; n_we = 1'b1; data_i = 8'h00;
        par_en = 1'b0; par_odd = 1'b0; big_end = 1'b0; two_stop = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_empty", p_empty, 1);
        check_val("rst_full", p_full, 0);
        check_val("rst_level", level, 0);
        @(negedge clk);
        rst = 1'b0;

        // 0x55, no parity, LSB first, one stop
        push_word(8'h55, 1'b1);
        end_write();
        #2;
        check_val("lvl_one", level, 1);
        check_val("not_empty", p_empty, 0);
        d0 = done_cnt;
        baud_en = 1'b1;
        wait_idle(400);
        check_val("done_55", done_cnt - d0, 1);

        // 0xA3, even parity, MSB first, two stops; config flipped mid-frame must not matter
        par_en = 1'b1; par_odd = 1'b0; big_end = 1'b1; two_stop = 1'b1;
        d0 = done_cnt;
        push_word(8'hA3, 1'b1);
        end_write();
        wait_busy(100);
        par_en = 1'b0; par_odd = 1'b1; big_end = 1'b0; two_stop = 1'b0;
        wait_idle(400);
        check_val("done_a3", done_cnt - d0, 1);

        // three back-to-back frames, odd parity
        par_en = 1'b1; par_odd = 1'b1; big_end = 1'b0; two_stop = 1'b0;
        push_word(8'h11, 1'b1);
        push_word(8'h80, 1'b1);
        push_word(8'hFE, 1'b1);
        end_write();
        wait_busy(100);
        begin
            int gaps = 0;
            int dn = 0;
            int t = 0;
            while (dn < 3 && t < 1000) begin
                @(negedge clk);
                #2;
                t++;
                if (done === 1'b1) dn++;
                if (dn < 3 && busy !== 1'b1) gaps++;
            end
            check_val("b2b_gaps", gaps, 0);
            check_val("b2b_done", dn, 3);
        end
        wait_idle(400);

        // simultaneous write and pop leaves level unchanged
        par_en = 1'b0; par_odd = 1'b0; big_end = 1'b0; two_stop = 1'b0;
        baud_en = 1'b0;
        repeat (4) @(negedge clk);
        push_word(8'h01, 1'b1);
        push_word(8'h02, 1'b1);
        end_write();
        #2;
        check_val("lvl_two", level, 2);
        push_word(8'h03, 1'b1);
        baud_force = 1'b1;
        @(negedge clk);
        n_we = 1'b1;
        baud_force = 1'b0;
        #2;
        check_val("wr_pop_lvl", level, 2);
        baud_en = 1'b1;
        wait_idle(600);

        // fill to full; 33rd word lost; write while full ignored even with a pop
        baud_en = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 33; i++) begin
            push_word(8'(i * 7 + 1), i < 32);
        end
        end_write();
        #2;
        check_val("full_flag", p_full, 1);
        check_val("full_level", level, 32);
        check_val("full_empty", p_empty, 0);
        @(negedge clk);
        data_i = 8'hEE;
        n_we = 1'b0;
        baud_force = 1'b1;
        @(negedge clk);
        n_we = 1'b1;
        baud_force = 1'b0;
        #2;
        check_val("full_wr_pop_lvl", level, 31);
        check_val("full_clear", p_full, 0);
        baud_en = 1'b1;
        wait_idle(3000);

        // reset during data bit 3 aborts the frame cleanly
        push_word(8'h00, 1'b1);
        push_word(8'h5A, 1'b1);
        end_write();
        begin
            int t = 0;
            while (!(in_frame && got_n == 5) && t < 200) begin
                @(negedge clk);
                #2;
                t++;
            end
        end
        check_val("pre_rst_tx", tx, 0);
        rst = 1'b1;
        mon_flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_val("rst_mid_tx", tx, 1);
        check_val("rst_mid_level", level, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_empty", p_empty, 1);
        d0 = done_cnt;
        push_word(8'h3C, 1'b1);
        end_write();
        wait_idle(400);
        check_val("post_rst_done", done_cnt - d0, 1);

`ifdef UART_TX_BREAK_EN
        // 20-period break, then one high period, then the pending frame
        begin
            int low = 0;
            int t = 0;
            int unsigned sn;
            mon_hold = 1'b1;
            brk = 1'b1;
            push_word(8'h96, 1'b1);
            end_write();
            sn = sample_n;
            while (low < 20 && t < 400) begin
                @(negedge clk);
                #2;
                t++;
                if (sample_n != sn) begin
                    sn = sample_n;
                    if (last_bit === 1'b0) low++;
                    else if (low != 0) t = 400;
                end
            end
            brk = 1'b0;
            check_val("brk_low", low, 20);
            check_val("brk_level", level, 1);
            check_val("brk_busy", busy, 1);
            t = 0;
            while (sample_n == sn && t < 40) begin
                @(negedge clk);
                #2;
                t++;
            end
            check_val("brk_gap", last_bit, 1);
            mon_hold = 1'b0;
            wait_idle(400);
        end
`endif

        check_val("spurious", spurious, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 32, meaning FIFO word count; power of two, 4..256.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  system clock, >=40 MHz.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port data_i  input  DATA_W  write data.
REQ-007 Port n_we_i  input  1  FIFO write strobe, active-low, one word per clk it is low.
REQ-008 Port p_full_o  output  1  FIFO full.
REQ-009 Port p_empty_o  output  1  FIFO empty.
REQ-010 Port level_o  output  log2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 Port p_BaudSig_i  input  1  one-clk pulse per bit period.
REQ-012 Port p_ParityEnable_i  input  1  1 = append parity bit.
REQ-013 Port ParityMethod_i  input  1  0 = even, 1 = odd.
REQ-014 Port p_BigEnd_i  input  1  1 = MSB first, 0 = LSB first.
REQ-015 Port p_TwoStop_i  input  1  1 = two stop bits, 0 = one.
REQ-016 Port Tx_o  output  1  serial line, idle high.
REQ-017 Port p_Busy_o  output  1  high from frame start until last stop bit ends.
REQ-018 Port p_Done_o  output  1  one-clk pulse at end of each frame.

Function
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2; transitions occur only on clocks with p_BaudSig_i=1.
REQ-020 IDLE with p_empty_o=0 on a baud pulse: pop one word, latch word plus p_ParityEnable_i, ParityMethod_i, p_BigEnd_i, p_TwoStop_i; next state START; Tx_o=0 from the following clk.
REQ-021 Config inputs changed mid-frame SHALL NOT affect the frame in progress.
REQ-022 START -> DATA after one bit period; DATA SHALL emit exactly DATA_W bits using a bit counter, order per latched p_BigEnd_i.
REQ-023 DATA -> PARITY if parity latched enabled, else STOP1; parity bit = XOR of data bits (even) or its inverse (odd).
REQ-024 STOP1/STOP2 SHALL drive Tx_o=1; STOP1 -> STOP2 only if two-stop latched.
REQ-025 On the baud pulse ending the last stop bit: p_Done_o=1 for that clk; if FIFO non-empty, pop and enter START with no idle bit; else enter IDLE.
REQ-026 Tx_o SHALL be registered; no combinational glitch path from inputs.
REQ-027 FIFO SHALL be first-word-fall-through; write with p_full_o=1 SHALL be ignored, even if a pop occurs the same clk.
REQ-028 Write and pop in the same clk with FIFO neither full nor empty: level_o unchanged, both performed.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; level_o updates the clk after each write/pop.
REQ-030 p_Busy_o SHALL be 0 only in IDLE.

Reset
REQ-031 On rst=1 at a clk edge: state IDLE, FIFO emptied, level_o=0, p_empty_o=1, p_full_o=0, Tx_o=1, p_Busy_o=0, p_Done_o=0.
REQ-032 Reset mid-frame SHALL abort the frame; Tx_o=1 the clk after reset, no partial bits resumed.

Configuration
REQ-033 Macro UART_TX_BREAK_EN SHALL add input p_Break_i (1 bit).
REQ-034 With UART_TX_BREAK_EN: p_Break_i=1 sampled in IDLE forces Tx_o=0 and p_Busy_o=1 until p_Break_i=0, then at least one full high bit period before next frame; FIFO not popped meanwhile; p_Break_i ignored mid-frame.
REQ-035 Without UART_TX_BREAK_EN: no p_Break_i port, no break logic.

Verification
REQ-036 DATA_W=8, write 0x55, parity off, LSB first, one stop -> Tx_o: 0,1,0,1,0,1,0,1,0,1, then one p_Done_o pulse.
REQ-037 Write 0xA3, parity even, MSB first, two stops -> 0,1,0,1,0,0,0,1,1,0(parity),1,1.
REQ-038 Write 3 words back-to-back -> three frames with no idle bit between, p_Busy_o high throughout, 3 Done pulses.
REQ-039 FIFO_DEPTH=32, 33 writes with no baud -> p_full_o=1, level_o=32, 33rd word lost; then drain -> 32 frames in order.
REQ-040 rst asserted at DATA bit 3 -> Tx_o=1, level_o=0 next clk; new write transmits a clean frame.
REQ-041 UART_TX_BREAK_EN defined, p_Break_i=1 for 20 baud periods -> Tx_o low 20 periods, >=1 high period, then pending frame.
